ucdp_clk_div: RTL
=================

// Module: ucdp_clk_div
// PURPOSE
//  Programmable integer clock divider: derives divided clock clk_o and one-cycle enable clk_en_o from clk_i.
//  Divisor changes and start/stop take effect only at period boundaries, so clk_o never glitches or has runt pulses.
//  Sits in clock-generation logic, upstream of clock muxes/combiners; clk_en_o serves clk_i-domain logic needing the divided rate.
// PARAMETERS
//  WIDTH        8   width of divisor value div_i
//  DEFAULT_DIV  2   divisor active after reset (clamped to >= 2)
// PORTS
//  clk_i       in   1      clock
//  rst_an_i    in   1      reset, synchronous, active-low
//  en_i        in   1      run request; level
//  div_i       in   WIDTH  new divisor D; stable while upd_req_i=1
//  upd_req_i   in   1      divisor update request; held until upd_ack_o
//  upd_ack_o   out  1      one-cycle pulse: div_i loaded
//  clk_o       out  1      divided clock, registered
//  clk_en_o    out  1      one-cycle pulse in last clk_i cycle of each clk_o period
//  busy_o      out  1      divider running or draining (state != IDLE)
// BEHAVIOUR
//  - Reset (rst_an_i=0 at clk_i edge): state=IDLE, cnt=0, div=max(DEFAULT_DIV,2); clk_o=0, clk_en_o=0, upd_ack_o=0, busy_o=0.
//    Reset wins over all other inputs; mid-period reset truncates clk_o immediately (low next edge).
//  - Clamp: any loaded div_i < 2 becomes 2; D = active divisor, H = floor(D/2).
//  - States: IDLE -> RUN when en_i=1; RUN -> STOP when en_i=0; STOP -> RUN when en_i=1 (no period restart);
//    STOP -> IDLE at period wrap (cnt=D-1). Only STOP->IDLE and IDLE->RUN alter period start.
//  - Counter: in RUN/STOP cnt increments each cycle, wraps D-1 -> 0; in IDLE cnt held 0.
//  - clk_o: registered, 1 while cnt in [0,H-1], 0 for [H,D-1]; rises on edge where cnt becomes 0; IDLE: 0.
//    Latency: en_i sampled high in IDLE -> clk_o=1 at next edge.
//  - clk_en_o = 1 in the cycle with cnt=D-1 (RUN or STOP), else 0; in the cycle before each clk_o rise and before STOP->IDLE.
//  - Update: upd_req_i=1 in IDLE -> div loaded, upd_ack_o=1 at next edge. In RUN/STOP -> load and ack on the wrap
//    edge (cnt D-1 -> 0); new D governs the following period. Requester drops upd_req_i the cycle after ack;
//    request still high in ack cycle is not re-acked (one ack per rising edge of upd_req_i).
//  - Simultaneous: wrap + update + en_i=0 in STOP -> divisor loaded, ack, state IDLE.
//  - Max divisor 2^WIDTH-1; no overflow path (cnt is WIDTH bits).
// CONFIGURATION
//  UCDP_CLK_DIV_DUTY50_EN defined: odd D gives 50% duty; extra negedge-clk_i flop (sync reset) delays high phase;
//    clk_o = posedge flop | negedge flop, high for H+0.5 clk_i periods. Even D unchanged.
//  Not defined: no negedge flop; odd D high for H cycles, low H+1 cycles. Port list identical both ways.
// STRUCTURE
//  Package ucdp_clk_div_pkg: state enum typedef (IDLE, RUN, STOP), localparam DIV_MIN=2.
//  Single module, no sub-module; counter, FSM, update logic and optional duty flop in one file.
// TESTING
//  - Reset, en_i=1, DEFAULT_DIV=2 -> clk_o toggles every clk_i cycle, clk_en_o=1 every 2nd cycle, first clk_o=1 one edge after en_i.
//  - D=5 while running -> upd_ack_o on next wrap edge; then clk_o 2 high/3 low (DUTY50 on: 2.5/2.5 clk_i periods).
//  - div_i=0 and 1 -> both load as D=2; div_i=255 (WIDTH=8) -> period 255, high 127 cycles.
//  - en_i=0 at cnt=1 with D=6 -> busy_o=1 until cnt=5, clk_en_o pulse, then IDLE, clk_o=0; re-enable at cnt=3 -> no restart, period intact.
//  - rst_an_i=0 mid-high-phase -> next edge clk_o=0, busy_o=0, upd_ack_o=0, div=DEFAULT_DIV.
//  - upd_req_i held 3 cycles past ack -> exactly one upd_ack_o pulse; divisor loaded once.

Source files
------------

// File: rtl/ucdp_clk_div_pkg.sv
// Shared types and constants for the programmable integer clock divider.
package ucdp_clk_div_pkg;

  // Divider run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // stopped, clk_o low, counter parked at 0
    RUN  = 2'd1,  // counting, run request present
    STOP = 2'd2   // run request gone, finishing the current period
  } state_e;

  // Smallest divisor that still yields a high and a low phase.
  localparam int unsigned DIV_MIN = 2;

  // Raise any divisor below DIV_MIN to DIV_MIN.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage : ucdp_clk_div_pkg

// File: rtl/ucdp_clk_div.sv
// Programmable integer clock divider.
// Derives a registered divided clock clk_o and a one-cycle enable clk_en_o
// (last clk_i cycle of every clk_o period) from clk_i. Divisor updates and
// start/stop only take effect on period boundaries, so clk_o has no runts.
// Optional build macro: UCDP_CLK_DIV_DUTY50_EN adds a negedge flop that
// stretches the high phase of odd divisors by half a clk_i period (50% duty).
module ucdp_clk_div
  import ucdp_clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             upd_req_i,
  output logic             upd_ack_o,
  output logic             clk_o,
  output logic             clk_en_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(clamp_div(DEFAULT_DIV));
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;   // current request already acknowledged

  logic             wrap;             // last cycle of the running period
  logic             upd_pend;         // request not yet served
  logic             load;             // divisor is taken this cycle
  logic [WIDTH-1:0] div_load;         // clamped incoming divisor

  assign wrap     = (state_q != IDLE) && (cnt_q == (div_q - ONE));
  assign upd_pend = upd_req_i && !done_q;
  assign load     = upd_pend && ((state_q == IDLE) || wrap);
  assign div_load = (div_i < MIN_DIV) ? MIN_DIV : div_i;

  // Next-state, counter, divisor-update and clock-phase decode.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ack_d   = 1'b0;
    done_d  = done_q;

    // A request is served once; it re-arms only after the requester drops it.
    if (!upd_req_i) begin
      done_d = 1'b0;
    end

    // New divisor lands at the period boundary and governs the next period.
    if (load) begin
      div_d  = div_load;
      ack_d  = 1'b1;
      done_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (!en_i) begin
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        // Re-enable resumes the current period; otherwise drain to its end.
        if (en_i) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // High for the first floor(D/2) counts of the period that starts now.
    clk_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_an_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      clk_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

`ifdef UCDP_CLK_DIV_DUTY50_EN
  logic clk_neg_q;

  // Half-period extension of the high phase when the active divisor is odd.
  always_ff @(negedge clk_i) begin
    if (!rst_an_i) begin
      clk_neg_q <= 1'b0;
    end else begin
      clk_neg_q <= clk_q & div_q[0];
    end
  end

  assign clk_o = clk_q | clk_neg_q;
`else
  assign clk_o = clk_q;
`endif

  assign clk_en_o  = wrap;
  assign upd_ack_o = ack_q;
  assign busy_o    = (state_q != IDLE);

endmodule : ucdp_clk_div
